// File: rtl/module_operand_entry_pkg.sv
// Shared keypad constants and the operand-entry state type.
package pkg_keypad;

    localparam int OPER_W = 8;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_BACK  = 4'hC;

    typedef enum logic [1:0] {
        S_NUM1,
        S_NUM2,
        S_WAIT,
        S_DONE
    } entry_state_t;

endpackage

// File: rtl/module_operand_entry_operand_acc.sv
// One decimal operand accumulator: digit append with range/length check,
// backspace by divide-by-10, and a clear that can combine with a new digit.
module operand_acc
    import pkg_keypad::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_digit,
    input  logic              back,
    input  logic              clr,
    input  logic [3:0]        digit,
    output logic [OPER_W-1:0] value,
    output logic [CNT_W-1:0]  count
);

    logic [OPER_W-1:0] value_q, value_d, base_v;
    logic [CNT_W-1:0]  count_q, count_d, base_c;
    logic [11:0]       cand;

    always_comb begin
        // Clear is applied first so a restart digit lands in an empty operand.
        base_v  = clr ? '0 : value_q;
        base_c  = clr ? '0 : count_q;
        cand    = 12'(base_v) * 12'd10 + 12'(digit);
        value_d = base_v;
        count_d = base_c;
        if (load_digit) begin
            if ((int'(base_c) < MAX_DIGITS) && (cand <= 12'd255)) begin
                value_d = cand[OPER_W-1:0];
                count_d = base_c + CNT_W'(1);
            end
        end else if (back && (base_c != '0)) begin
            value_d = base_v / OPER_W'(10);
            count_d = base_c - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/module_operand_entry.sv
// Keypad operand entry: builds two operands from digit keys, raises the
// listo_* status levels and runs the start/done handshake with the multiplier.
module module_operand_entry
    import pkg_keypad::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              mul_done,
    output logic [OPER_W-1:0] num_1,
    output logic [OPER_W-1:0] num_2,
    output logic              listo_1,
    output logic              listo_2,
    output logic              listo,
    output logic              mul_start
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    entry_state_t state_q;
    logic listo_1_q, listo_2_q, listo_q, mul_start_q;

    logic is_digit, is_enter, is_clear, is_back;
    logic clr_all, ld1, ld2, bk1, bk2;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic [2*CNT_W-1:0] unused_cnt;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_enter = key_valid && (key_code == KEY_ENTER);
    assign is_clear = key_valid && (key_code == KEY_CLEAR);
    assign is_back  = key_valid && (key_code == KEY_BACK);

    // A digit in S_DONE wipes everything and becomes the first digit of num_1.
    assign clr_all = is_clear || (is_digit && (state_q == S_DONE));
    assign ld1     = is_digit && ((state_q == S_NUM1) || (state_q == S_DONE));
    assign ld2     = is_digit && (state_q == S_NUM2);
    assign bk1     = is_back && (state_q == S_NUM1);
    assign bk2     = is_back && (state_q == S_NUM2);

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc1 (
        .clk        (clk),
        .rst        (rst),
        .load_digit (ld1),
        .back       (bk1),
        .clr        (clr_all),
        .digit      (key_code),
        .value      (num_1),
        .count      (cnt1)
    );

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc2 (
        .clk        (clk),
        .rst        (rst),
        .load_digit (ld2),
        .back       (bk2),
        .clr        (clr_all),
        .digit      (key_code),
        .value      (num_2),
        .count      (cnt2)
    );

    assign unused_cnt = {cnt1, cnt2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_NUM1;
            listo_1_q   <= 1'b0;
            listo_2_q   <= 1'b0;
            listo_q     <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            if (is_clear) begin
                state_q   <= S_NUM1;
                listo_1_q <= 1'b0;
                listo_2_q <= 1'b0;
                listo_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_NUM1: if (is_enter) begin
                        state_q   <= S_NUM2;
                        listo_1_q <= 1'b1;
                    end
                    S_NUM2: if (is_enter) begin
                        state_q     <= S_WAIT;
                        listo_2_q   <= 1'b1;
                        mul_start_q <= 1'b1;
                    end
                    S_WAIT: if (mul_done) begin
                        state_q <= S_DONE;
                        listo_q <= 1'b1;
                    end
                    S_DONE: if (is_digit) begin
                        state_q   <= S_NUM1;
                        listo_1_q <= 1'b0;
                        listo_2_q <= 1'b0;
                        listo_q   <= 1'b0;
                    end
                    default: state_q <= S_NUM1;
                endcase
            end
        end
    end

    assign listo_1   = listo_1_q;
    assign listo_2   = listo_2_q;
    assign listo     = listo_q;
    assign mul_start = mul_start_q;

endmodule

// File: doc/module_operand_entry.md
# module_operand_entry

Keypad-side producer of the operand/ready interface consumed by the display priority selector and the multiplier. It accumulates decimal key presses into two 8-bit unsigned operands and publishes them live while they are typed. It raises the `listo_1`/`listo_2`/`listo` status levels as each stage completes, and runs a start/done handshake with the multiplier.

## Interface
- `MAX_DIGITS`, 3: maximum decimal digits accepted per operand.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; clears all state and outputs.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle (already debounced upstream).
- `key_code`  in  4  key code:
  - 0–9: digits.
  - `KEY_ENTER` = 4'hA.
  - `KEY_CLEAR` = 4'hB.
  - `KEY_BACK` = 4'hC.
  - 4'hD–4'hF: ignored.
- `mul_done`  in  1  multiplier result valid strobe (level or pulse accepted).
- `num_1`  out  8  operand 1, live value during entry, then held.
- `num_2`  out  8  operand 2, live value during entry, then held.
- `listo_1`  out  1  level; operand 1 committed.
- `listo_2`  out  1  level; operand 2 committed.
- `listo`  out  1  level; multiplier result valid for display.
- `mul_start`  out  1  one-cycle pulse requesting a multiplication of `num_1` × `num_2`.

## Operation
- **States:** `S_NUM1`, `S_NUM2`, `S_WAIT`, `S_DONE`. Reset state is `S_NUM1`.
- **Outputs at reset:** `num_1` = `num_2` = 0; `listo_1` = `listo_2` = `listo` = `mul_start` = 0; digit counters 0.
- **Digit d in `S_NUM1` / `S_NUM2`** (applies to the active operand v, with digit count c):
  - Accepted only if c < `MAX_DIGITS` and v*10+d ≤ 255. On acceptance, v ← v*10+d and c ← c+1.
  - Otherwise the key is dropped and v and c are unchanged. Compute v*10+d at 12 bits before the range check.
- **`KEY_BACK` in `S_NUM1` / `S_NUM2`:** if c > 0, v ← v/10 and c ← c−1. Otherwise no effect. Backspace never crosses back into the previous operand.
- **`KEY_ENTER`:**
  - In `S_NUM1`: go to `S_NUM2` and set `listo_1`=1. An empty entry commits 0.
  - In `S_NUM2`: go to `S_WAIT`, set `listo_2`=1, and pulse `mul_start`.
- **`KEY_CLEAR`:** in any state, go to `S_NUM1` and clear `num_1`, `num_2`, counters, and all flags. If `mul_done` arrives in the same cycle, the clear wins.
- **`S_WAIT`:**
  - Digit, ENTER, and BACK keys are ignored.
  - `mul_done`=1 moves to `S_DONE` and sets `listo`=1.
- **`S_DONE`:**
  - `listo_1`, `listo_2`, and `listo` all stay 1.
  - A digit key starts a new entry: both operands and the flags are cleared, the state goes to `S_NUM1`, and the digit is loaded as the first digit of `num_1` in the same update.
  - ENTER and BACK are ignored.
- `mul_done` outside `S_WAIT` is ignored.
- Codes 4'hD–4'hF are ignored in every state.

## Timing
- One key is processed per cycle. The effect of a key appears on the outputs in the cycle after the `key_valid` edge.
- `mul_start` is high for exactly one cycle: the cycle after ENTER is sampled in `S_NUM2`.
- `listo` rises the cycle after `mul_done` is sampled high in `S_WAIT`.
- Back-to-back `key_valid` strobes on consecutive cycles are each processed.
- `rst` overrides `key_valid` and `mul_done` in the same cycle.
- Reset mid-entry or mid-`S_WAIT`: the block returns to reset values in the next cycle. No `mul_start` is issued.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- **Package `pkg_keypad`:**
  - Key code constants `KEY_ENTER`, `KEY_CLEAR`, `KEY_BACK`.
  - The state enum `entry_state_t`.
  - The operand width constant `OPER_W` = 8.
- **Sub-module `operand_acc`** (two instances):
  - Holds one operand value and its digit counter.
  - Inputs: `load_digit`, `back`, `clr`, `digit`.
  - Outputs: `value`, `count`.
  - Implements the accept, range-check, and divide-by-10 rules.
- The top level contains the FSM, the flags, and the `mul_start` generation.

## Test plan
- **Basic multiply:** keys 1,2,ENTER,3,4,ENTER.
  - `num_1`=12 with `listo_1`=1.
  - Then `num_2`=34 with `listo_2`=1 and a single `mul_start` pulse.
  - `mul_done` three cycles later → `listo`=1 on the next cycle.
- **Overflow and digit limit:** keys 2,5,6.
  - The 6 is rejected; `num_1` stays 25.
  - Then 5 → 255; a further digit 0 → rejected (count is 3).
- **Backspace:** keys 1,2,3,BACK,BACK,BACK,BACK.
  - `num_1` goes 123 → 12 → 1 → 0 → 0.
  - The state remains `S_NUM1` and `listo_1` stays 0.
- **Empty entries and ignored keys:** ENTER,ENTER.
  - `num_1`=`num_2`=0 and `mul_start` pulses.
  - In `S_WAIT`, keys 7 and 4'hE → no change; a stray `mul_done` before ENTER was ignored.
- **Restart and clear:**
  - In `S_DONE`, key 9 → `num_1`=9, `num_2`=0, all flags 0.
  - CLEAR in `S_WAIT` together with `mul_done` → `S_NUM1`, `listo`=0.
- **Reset:** mid-`S_NUM2` with `num_2`=4 → all outputs 0 next cycle, with no `mul_start` pulse.
